// File: rtl/filter_tune_ctrl_pkg.sv
// filter_tune_pkg
// Shared definitions for the RC filter tuning sequencer:
//   - tune_state_e : sequencer states
//   - DEF_*        : default parameter values used by the interface and top
//   - settle_cycles: saturating settle-time computation for a given trim code
package filter_tune_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAKE   = 3'd1,
        RAMP   = 3'd2,
        SETTLE = 3'd3,
        LOCKED = 3'd4
    } tune_state_e;

    localparam int unsigned DEF_CODE_W      = 6;
    localparam int unsigned DEF_CODE_MAX    = 48;
    localparam int unsigned DEF_WAKE_CYC    = 16;
    localparam int unsigned DEF_STEP_CYC    = 4;
    localparam int unsigned DEF_SETTLE_BASE = 32;
    localparam int unsigned DEF_SETTLE_STEP = 8;
    localparam int unsigned DEF_CNT_W       = 16;

    // Settle time grows linearly with the final code (larger code -> larger
    // RC). The sum is formed in a wide integer so it cannot wrap, then
    // saturated to the largest value a cnt_w-bit timer can hold.
    function automatic longint unsigned settle_cycles(
        input longint unsigned code,
        input longint unsigned base,
        input longint unsigned step,
        input int unsigned     cnt_w
    );
        longint unsigned raw;
        longint unsigned lim;
        raw = base + code * step;
        lim = (64'd1 << cnt_w) - 64'd1;
        return (raw > lim) ? lim : raw;
    endfunction

endpackage

// File: rtl/filter_tune_ctrl_if.sv
// filter_tune_ctrl_if
// Configuration handshake between the register/config bus and the tuning
// sequencer.
//   cfg_valid : master -> slave, a target trim code is offered
//   cfg_code  : master -> slave, requested trim code
//   cfg_ready : slave -> master, the sequencer can accept a target
// A transfer happens on a rising edge where cfg_valid and cfg_ready are both 1.
interface filter_tune_ctrl_if
    import filter_tune_pkg::*;
#(
    parameter int unsigned CODE_W = DEF_CODE_W
);
    logic              cfg_valid;
    logic [CODE_W-1:0] cfg_code;
    logic              cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_code,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_code,
        output cfg_ready
    );
endinterface

// File: rtl/filter_tune_ctrl_timer.sv
// tune_timer
// Loadable down-counter shared by the WAKE, RAMP and SETTLE phases.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   value      : current count
//   zero       : count is zero
// The counter decrements by one each cycle while non-zero and holds at zero.
module tune_timer
    import filter_tune_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    // Next count: load wins, otherwise count down and stick at zero.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (value_q != '0) begin
            value_d = value_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == '0);

endmodule

// File: rtl/filter_tune_ctrl.sv
// filter_tune_ctrl
// Sequencer for the programmable RC low-pass filter. Wakes the filter, ramps
// the trim code one LSB per STEP_CYC cycles toward the requested target, waits
// a code-dependent settle time, then declares the output valid.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : level, 1 = filter in use
//   cfg         : config handshake (cfg_valid, cfg_code, cfg_ready)
//   flt_en      : filter powered
//   flt_bypass  : 1 = filter output bypassed
//   flt_code    : trim code applied to the filter
//   flt_hold    : 1 while the code is moving
//   settled     : filter output valid
//   clamp_err   : one-cycle pulse when a requested code exceeded CODE_MAX
module filter_tune_ctrl
    import filter_tune_pkg::*;
#(
    parameter int unsigned CODE_W      = DEF_CODE_W,
    parameter int unsigned CODE_MAX    = DEF_CODE_MAX,
    parameter int unsigned WAKE_CYC    = DEF_WAKE_CYC,
    parameter int unsigned STEP_CYC    = DEF_STEP_CYC,
    parameter int unsigned SETTLE_BASE = DEF_SETTLE_BASE,
    parameter int unsigned SETTLE_STEP = DEF_SETTLE_STEP,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    filter_tune_ctrl_if.slave        cfg,
    output logic                     flt_en,
    output logic                     flt_bypass,
    output logic [CODE_W-1:0]        flt_code,
    output logic                     flt_hold,
    output logic                     settled,
    output logic                     clamp_err
);

    localparam logic [CODE_W-1:0] CODE_MAX_C = CODE_W'(CODE_MAX);
    localparam logic [CNT_W-1:0]  WAKE_LOAD  = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0]  STEP_LOAD  = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    tune_state_e       state_q, state_d;
    logic [CODE_W-1:0] target_q, target_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              flt_en_q, flt_en_d;
    logic              flt_bypass_q, flt_bypass_d;
    logic              flt_hold_q, flt_hold_d;
    logic              settled_q, settled_d;
    logic              clamp_err_q, clamp_err_d;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_load_val;
    logic [CNT_W-1:0]  tmr_value;
    logic              tmr_zero;
    logic              xfer;

    tune_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    // cfg_ready is the only output decoded directly from the state register.
    assign cfg.cfg_ready = (state_q == IDLE) || (state_q == SETTLE) || (state_q == LOCKED);
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;

    // Next-state, target/code update and timer control.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        code_d       = code_q;
        clamp_err_d  = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        // A transfer can be accepted in IDLE, SETTLE and LOCKED; the target
        // is captured clamped, independent of what the state does next.
        if (xfer) begin
            if (cfg.cfg_code > CODE_MAX_C) begin
                target_d    = CODE_MAX_C;
                clamp_err_d = 1'b1;
            end else begin
                target_d = cfg.cfg_code;
            end
        end

        if (!enable) begin
            // Disable from anywhere: code and target freeze, timer clears.
            state_d  = IDLE;
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d      = WAKE;
                    tmr_load     = 1'b1;
                    tmr_load_val = WAKE_LOAD;
                end
                WAKE: begin
                    if (tmr_zero) begin
                        state_d      = RAMP;
                        tmr_load     = 1'b1;
                        tmr_load_val = STEP_LOAD;
                    end
                end
                RAMP: begin
                    if (code_q == target_q) begin
                        state_d      = SETTLE;
                        tmr_load     = 1'b1;
                        tmr_load_val = CNT_W'(settle_cycles(64'(code_q), 64'(SETTLE_BASE),
                                                            64'(SETTLE_STEP), CNT_W));
                    end else if (tmr_zero) begin
                        code_d   = (code_q < target_q) ? code_q + 1'b1 : code_q - 1'b1;
                        tmr_load = 1'b1;
                        if (code_d == target_q) begin
                            state_d      = SETTLE;
                            tmr_load_val = CNT_W'(settle_cycles(64'(code_d), 64'(SETTLE_BASE),
                                                                64'(SETTLE_STEP), CNT_W));
                        end else begin
                            tmr_load_val = STEP_LOAD;
                        end
                    end
                end
                SETTLE: begin
                    // Leaving while the count is 1 (or 0) makes SETTLE last
                    // exactly the loaded number of cycles, minimum one.
                    if (xfer) begin
                        state_d      = RAMP;
                        tmr_load     = 1'b1;
                        tmr_load_val = STEP_LOAD;
                    end else if (tmr_value <= CNT_ONE) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        state_d      = RAMP;
                        tmr_load     = 1'b1;
                        tmr_load_val = STEP_LOAD;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        flt_en_d     = (state_d != IDLE);
        flt_bypass_d = (state_d != LOCKED);
        flt_hold_d   = (state_d == RAMP);
        settled_d    = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            target_q     <= '0;
            code_q       <= '0;
            flt_en_q     <= 1'b0;
            flt_bypass_q <= 1'b1;
            flt_hold_q   <= 1'b0;
            settled_q    <= 1'b0;
            clamp_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            code_q       <= code_d;
            flt_en_q     <= flt_en_d;
            flt_bypass_q <= flt_bypass_d;
            flt_hold_q   <= flt_hold_d;
            settled_q    <= settled_d;
            clamp_err_q  <= clamp_err_d;
        end
    end

    assign flt_en     = flt_en_q;
    assign flt_bypass = flt_bypass_q;
    assign flt_code   = code_q;
    assign flt_hold   = flt_hold_q;
    assign settled    = settled_q;
    assign clamp_err  = clamp_err_q;

endmodule

// File: tb/tb_filter_tune_ctrl.sv
// tb_filter_tune_ctrl
// Directed bench for filter_tune_ctrl with default parameters. Inputs change
// and outputs are sampled on the falling clock edge. Edge numbers in the
// comments count rising edges from a local origin: edge 0 is the first rising
// edge after the inputs were set.
module tb_filter_tune_ctrl;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       flt_en;
    logic       flt_bypass;
    logic [5:0] flt_code;
    logic       flt_hold;
    logic       settled;
    logic       clamp_err;

    int n_cmp;
    int n_err;
    int cur;

    filter_tune_ctrl_if #(.CODE_W(6)) cfg_bus ();

    filter_tune_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .cfg        (cfg_bus),
        .flt_en     (flt_en),
        .flt_bypass (flt_bypass),
        .flt_code   (flt_code),
        .flt_hold   (flt_hold),
        .settled    (settled),
        .clamp_err  (clamp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence never completes.
    initial begin
        #1000000;
        $display("[TB] FAIL timeout: observed no completion, expected finish before 1 ms");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Move to the falling edge that follows rising edge e of the local origin.
    task automatic advance_to(input int e);
        repeat (e - cur) @(negedge clk);
        cur = e;
    endtask

    task automatic apply_stimulus(input logic valid, input logic [5:0] code);
        cfg_bus.cfg_valid = valid;
        cfg_bus.cfg_code  = code;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cur   = 0;
        rst_n = 1'b0;
        enable = 1'b0;
        apply_stimulus(1'b0, 6'd0);

        // Reset held for 5 cycles with random inputs.
        repeat (5) begin
            @(negedge clk);
            enable = 1'($urandom_range(0, 1));
            apply_stimulus(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
        end
        @(negedge clk);
        check_output("rst_flt_en", flt_en, 0);
        check_output("rst_bypass", flt_bypass, 1);
        check_output("rst_code", flt_code, 0);
        check_output("rst_hold", flt_hold, 0);
        check_output("rst_settled", settled, 0);
        check_output("rst_clamp", clamp_err, 0);
        check_output("rst_ready", cfg_bus.cfg_ready, 1);
        enable = 1'b0;
        apply_stimulus(1'b0, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold lock: target 3 stored in IDLE, then enable.
        apply_stimulus(1'b1, 6'd3);
        @(negedge clk);
        apply_stimulus(1'b0, 6'd0);
        check_output("idle_xfer_code", flt_code, 0);
        check_output("idle_xfer_en", flt_en, 0);
        check_output("idle_xfer_clamp", clamp_err, 0);
        enable = 1'b1;
        cur = -1;
        advance_to(0);
        check_output("wake_en", flt_en, 1);
        check_output("wake_ready", cfg_bus.cfg_ready, 0);
        check_output("wake_hold", flt_hold, 0);
        advance_to(15);
        check_output("wake_e15_hold", flt_hold, 0);
        advance_to(16);
        check_output("ramp_e16_hold", flt_hold, 1);
        advance_to(19);
        check_output("ramp_e19_code", flt_code, 0);
        advance_to(20);
        check_output("ramp_e20_code", flt_code, 1);
        advance_to(24);
        check_output("ramp_e24_code", flt_code, 2);
        advance_to(28);
        check_output("ramp_e28_code", flt_code, 3);
        check_output("settle_e28_hold", flt_hold, 0);
        check_output("settle_e28_ready", cfg_bus.cfg_ready, 1);
        advance_to(83);
        check_output("settle_e83_settled", settled, 0);
        advance_to(84);
        check_output("lock_e84_settled", settled, 1);
        check_output("lock_e84_bypass", flt_bypass, 0);

        // Retune down from 3 to 1.
        apply_stimulus(1'b1, 6'd1);
        cur = -1;
        advance_to(0);
        apply_stimulus(1'b0, 6'd0);
        check_output("retune_settled_drop", settled, 0);
        check_output("retune_hold", flt_hold, 1);
        check_output("retune_e0_code", flt_code, 3);
        advance_to(4);
        check_output("retune_e4_code", flt_code, 2);
        advance_to(8);
        check_output("retune_e8_code", flt_code, 1);
        advance_to(47);
        check_output("retune_e47_settled", settled, 0);
        advance_to(48);
        check_output("retune_e48_settled", settled, 1);

        // Clamp: 60 requested, ramps to 48.
        apply_stimulus(1'b1, 6'd60);
        cur = -1;
        advance_to(0);
        apply_stimulus(1'b0, 6'd0);
        check_output("clamp_pulse", clamp_err, 1);
        advance_to(1);
        check_output("clamp_pulse_end", clamp_err, 0);
        advance_to(187);
        check_output("clamp_e187_code", flt_code, 47);
        advance_to(188);
        check_output("clamp_e188_code", flt_code, 48);
        advance_to(603);
        check_output("clamp_e603_settled", settled, 0);
        advance_to(604);
        check_output("clamp_e604_settled", settled, 1);

        // Same code again: RAMP pass-through then 416 settle cycles.
        apply_stimulus(1'b1, 6'd48);
        cur = -1;
        advance_to(0);
        apply_stimulus(1'b0, 6'd0);
        check_output("same_no_clamp", clamp_err, 0);
        check_output("same_hold", flt_hold, 1);
        advance_to(1);
        check_output("same_e1_hold", flt_hold, 0);
        advance_to(416);
        check_output("same_e416_settled", settled, 0);
        advance_to(417);
        check_output("same_e417_settled", settled, 1);

        // Move to 10 and lock there.
        apply_stimulus(1'b1, 6'd10);
        cur = -1;
        advance_to(0);
        apply_stimulus(1'b0, 6'd0);
        advance_to(152);
        check_output("to10_code", flt_code, 10);
        advance_to(264);
        check_output("to10_settled", settled, 1);

        // Disable mid-ramp from 10 toward 20.
        apply_stimulus(1'b1, 6'd20);
        cur = -1;
        advance_to(0);
        apply_stimulus(1'b0, 6'd0);
        advance_to(13);
        check_output("dis_e13_code", flt_code, 13);
        enable = 1'b0;
        advance_to(14);
        check_output("dis_flt_en", flt_en, 0);
        check_output("dis_hold", flt_hold, 0);
        check_output("dis_code", flt_code, 13);
        check_output("dis_ready", cfg_bus.cfg_ready, 1);
        advance_to(18);
        check_output("dis_frozen_code", flt_code, 13);

        // Re-enable: wake again, resume from 13.
        enable = 1'b1;
        cur = -1;
        advance_to(0);
        check_output("reen_flt_en", flt_en, 1);
        check_output("reen_code", flt_code, 13);
        advance_to(16);
        check_output("reen_e16_hold", flt_hold, 1);
        advance_to(20);
        check_output("reen_e20_code", flt_code, 14);
        advance_to(44);
        check_output("reen_e44_code", flt_code, 20);
        check_output("reen_e44_hold", flt_hold, 0);
        advance_to(60);

        // Asynchronous reset in the middle of SETTLE, between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_code", flt_code, 0);
        check_output("arst_flt_en", flt_en, 0);
        check_output("arst_bypass", flt_bypass, 1);
        check_output("arst_settled", settled, 0);
        check_output("arst_ready", cfg_bus.cfg_ready, 1);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("post_rst_flt_en", flt_en, 0);

        // Target equals code (both 0 after reset): add one pass-through cycle.
        enable = 1'b1;
        cur = -1;
        advance_to(16);
        check_output("eq_e16_hold", flt_hold, 1);
        advance_to(17);
        check_output("eq_e17_hold", flt_hold, 0);
        advance_to(48);
        check_output("eq_e48_settled", settled, 0);
        advance_to(49);
        check_output("eq_e49_settled", settled, 1);
        check_output("eq_e49_code", flt_code, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
